pic_rom_fetch_scheduler: RTL and testbench

Frame-level scheduler that shares one picture ROM between two on-screen picture windows (original and filtered path) in the HDMI display pipeline. It sits between the timing generator (`act_x`/`act_y`/`vs_in`) and the single-port picture ROM. It issues one ROM address per clock, placed a fixed lead time ahead of display, and tags each fetch with the window that owns it. Per-frame window enables are latched at frame start, so that reconfiguration never tears a frame.

---
 rtl/pic_rom_fetch_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_pic_rom_fetch_scheduler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pic_rom_fetch_scheduler.sv
// pic_rom_fetch_scheduler: shares one picture ROM between two display windows.
// Every pixel clock at most one ROM address is issued, LEAD cycles ahead of
// the display column, and tagged one-hot with the window that owns it.
// Window enables are captured once per frame (ARM) so a frame never tears.

// Per-window fetch tracker: region decode, address counter and done flag.
module pic_rom_fetch_win #(
    parameter int X_BITS    = 12,
    parameter int Y_BITS    = 12,
    parameter int ADDR_BITS = 16,
    parameter int PIC_W     = 256,
    parameter int PIC_H     = 256,
    parameter int WIN_X     = 640,
    parameter int WIN_Y     = 412,
    parameter int LEAD      = 5
) (
    input  logic                 pix_clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_adv,
    input  logic [X_BITS-1:0]    i_x,
    input  logic [Y_BITS-1:0]    i_y,
    output logic                 o_in_region,
    output logic [ADDR_BITS-1:0] o_cnt,
    output logic                 o_done
);
    // Bounds carry one extra bit so WIN_X-LEAD and the upper edges never wrap.
    localparam logic [X_BITS:0]    X_LO = (X_BITS+1)'(WIN_X - LEAD);
    localparam logic [X_BITS:0]    X_HI = (X_BITS+1)'(WIN_X - LEAD + PIC_W);
    localparam logic [Y_BITS:0]    Y_LO = (Y_BITS+1)'(WIN_Y);
    localparam logic [Y_BITS:0]    Y_HI = (Y_BITS+1)'(WIN_Y + PIC_H);
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(PIC_W * PIC_H - 1);

    logic [X_BITS:0]    w_x;
    logic [Y_BITS:0]    w_y;
    logic [ADDR_BITS-1:0] r_cnt;
    logic                 r_done;

    assign w_x = {1'b0, i_x};
    assign w_y = {1'b0, i_y};

    // Fetch region: display region shifted left by the fetch lead time.
    always_comb begin
        o_in_region = (w_x >= X_LO) && (w_x < X_HI) && (w_y >= Y_LO) && (w_y < Y_HI);
    end

    // Address counter advances only on a granted fetch; done marks the last pixel.
    always_ff @(posedge pix_clk) begin
        if (rst || i_clr) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_adv) begin
            r_cnt <= r_cnt + ADDR_BITS'(1);
            if (r_cnt == LAST) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = r_done;
endmodule

module pic_rom_fetch_scheduler #(
    parameter int X_BITS    = 12,
    parameter int Y_BITS    = 12,
    parameter int ADDR_BITS = 16,
    parameter int PIC_W     = 256,
    parameter int PIC_H     = 256,
    parameter int WIN0_X    = 640,
    parameter int WIN1_X    = 1024,
    parameter int WIN_Y     = 412,
    parameter int LEAD      = 5
) (
    input  logic                 pix_clk,
    input  logic                 rst,
    input  logic [X_BITS-1:0]    act_x,
    input  logic [Y_BITS-1:0]    act_y,
    input  logic                 vs_in,
    input  logic [1:0]           cfg_win_en,
    output logic [ADDR_BITS-1:0] rom_addr,
    output logic [1:0]           rom_sel,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 busy,
    output logic                 err_overlap
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic                      r_vs_d;
    logic                      w_vs_rise;
    logic [1:0]                r_en_q;
    logic                      r_err;
    logic [ADDR_BITS-1:0]      r_rom_addr;
    logic [1:0]                r_rom_sel;

    logic                      w_clr;
    logic                      w_active;
    logic [1:0]                w_in;
    logic [1:0]                w_done;
    logic [1:0]                w_hit;
    logic [1:0]                w_grant;
    logic [1:0][ADDR_BITS-1:0] w_cnt;
    logic                      w_all_done;

    assign w_vs_rise = vs_in & ~r_vs_d;
    assign w_clr     = (r_state == S_ARM);
    assign w_active  = (r_state == S_ACTIVE);

    for (genvar k = 0; k < 2; k++) begin : g_win
        pic_rom_fetch_win #(
            .X_BITS   (X_BITS),
            .Y_BITS   (Y_BITS),
            .ADDR_BITS(ADDR_BITS),
            .PIC_W    (PIC_W),
            .PIC_H    (PIC_H),
            .WIN_X    ((k == 0) ? WIN0_X : WIN1_X),
            .WIN_Y    (WIN_Y),
            .LEAD     (LEAD)
        ) u_win (
            .pix_clk    (pix_clk),
            .rst        (rst),
            .i_clr      (w_clr),
            .i_adv      (w_grant[k]),
            .i_x        (act_x),
            .i_y        (act_y),
            .o_in_region(w_in[k]),
            .o_cnt      (w_cnt[k]),
            .o_done     (w_done[k])
        );
        assign w_hit[k] = w_active & r_en_q[k] & ~w_done[k] & w_in[k];
    end

    // Window 0 has fixed priority; window 1 only fetches when window 0 is idle.
    always_comb begin
        w_grant    = 2'b00;
        w_grant[0] = w_hit[0];
        w_grant[1] = w_hit[1] & ~w_hit[0];
        w_all_done = &(w_done | ~r_en_q);
    end

    // Next-state and per-state pulses; a vs edge in ACTIVE resyncs without frame_done.
    always_comb begin
        w_state_nx  = r_state;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_vs_rise) w_state_nx = S_ARM;
            end
            S_ARM: begin
                frame_start = 1'b1;
                busy        = 1'b1;
                if (cfg_win_en != 2'b00) begin
                    w_state_nx = S_ACTIVE;
                end else begin
                    w_state_nx = S_DONE;
                    frame_done = 1'b1;
                end
            end
            S_ACTIVE: begin
                busy = 1'b1;
                if (w_vs_rise) begin
                    w_state_nx = S_ARM;
                end else if (w_all_done) begin
                    w_state_nx = S_DONE;
                    frame_done = 1'b1;
                end
            end
            S_DONE: begin
                if (w_vs_rise) w_state_nx = S_ARM;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State, vs edge history, per-frame enables and sticky overlap flag.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vs_d  <= 1'b0;
            r_en_q  <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_vs_d  <= vs_in;
            if (r_state == S_ARM) begin
                r_en_q <= cfg_win_en;
                r_err  <= 1'b0;
            end else if (w_hit[0] && w_hit[1]) begin
                r_err <= 1'b1;
            end
        end
    end

    // Registered ROM request: address of the granted window, or zero when idle.
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_rom_sel  <= 2'b00;
        end else if (w_grant[0]) begin
            r_rom_addr <= w_cnt[0];
            r_rom_sel  <= 2'b01;
        end else if (w_grant[1]) begin
            r_rom_addr <= w_cnt[1];
            r_rom_sel  <= 2'b10;
        end else begin
            r_rom_addr <= '0;
            r_rom_sel  <= 2'b00;
        end
    end

    assign rom_addr    = r_rom_addr;
    assign rom_sel     = r_rom_sel;
    assign err_overlap = r_err;
endmodule

// File: tb/tb_pic_rom_fetch_scheduler.sv
// Bench for pic_rom_fetch_scheduler: scaled-down geometry, two instances
// (separate windows and overlapping windows), directed frame schedule followed
// by random config changes, vs resyncs and resets, against a frame model.
module tb_pic_rom_fetch_scheduler;
    localparam int XB  = 6;
    localparam int YB  = 4;
    localparam int AB  = 5;
    localparam int PW  = 8;
    localparam int PH  = 4;
    localparam int W0  = 20;
    localparam int W1A = 40;
    localparam int W1B = 24;
    localparam int WY  = 3;
    localparam int LD  = 5;
    localparam int TOT = PW * PH;
    localparam int HT  = 48;
    localparam int VT  = 10;
    localparam int NFR = 40;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_ACT  = 2;
    localparam int P_DONE = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [XB-1:0] act_x;
    logic [YB-1:0] act_y;
    logic          vs_in;
    logic [1:0]    cfg;

    logic [AB-1:0] addr_a, addr_b;
    logic [1:0]    sel_a, sel_b;
    logic          fs_a, fs_b, fd_a, fd_b, busy_a, busy_b, err_a, err_b;

    always #5 clk = ~clk;

    pic_rom_fetch_scheduler #(
        .X_BITS(XB), .Y_BITS(YB), .ADDR_BITS(AB), .PIC_W(PW), .PIC_H(PH),
        .WIN0_X(W0), .WIN1_X(W1A), .WIN_Y(WY), .LEAD(LD)
    ) u_dut_a (
        .pix_clk(clk), .rst(rst), .act_x(act_x), .act_y(act_y), .vs_in(vs_in),
        .cfg_win_en(cfg), .rom_addr(addr_a), .rom_sel(sel_a), .frame_start(fs_a),
        .frame_done(fd_a), .busy(busy_a), .err_overlap(err_a)
    );

    pic_rom_fetch_scheduler #(
        .X_BITS(XB), .Y_BITS(YB), .ADDR_BITS(AB), .PIC_W(PW), .PIC_H(PH),
        .WIN0_X(W0), .WIN1_X(W1B), .WIN_Y(WY), .LEAD(LD)
    ) u_dut_b (
        .pix_clk(clk), .rst(rst), .act_x(act_x), .act_y(act_y), .vs_in(vs_in),
        .cfg_win_en(cfg), .rom_addr(addr_b), .rom_sel(sel_b), .frame_start(fs_b),
        .frame_done(fd_b), .busy(busy_b), .err_overlap(err_b)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Frame model: phase, fetches delivered per window, latched enables.
    int       m_ph   [2];
    int       m_n0   [2];
    int       m_n1   [2];
    bit [1:0] m_en   [2];
    bit       m_err  [2];
    int       m_addr [2];
    bit [1:0] m_sel  [2];
    bit       m_vsd  [2];

    function automatic bit in_reg(input int d, input int k, input int x, input int y);
        int lo;
        lo = ((k == 0) ? W0 : ((d == 0) ? W1A : W1B)) - LD;
        return (x >= lo) && (x < lo + PW) && (y >= WY) && (y < WY + PH);
    endfunction

    function automatic bit all_done(input int d);
        return (!m_en[d][0] || m_n0[d] == TOT) && (!m_en[d][1] || m_n1[d] == TOT);
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic step(input int d);
        bit vsr, h0, h1, ad;
        if (rst) begin
            m_ph[d] = P_IDLE; m_n0[d] = 0; m_n1[d] = 0; m_en[d] = 2'b00;
            m_err[d] = 1'b0; m_addr[d] = 0; m_sel[d] = 2'b00; m_vsd[d] = 1'b0;
            return;
        end
        vsr = vs_in && !m_vsd[d];
        m_vsd[d] = vs_in;
        ad = all_done(d);
        h0 = (m_ph[d] == P_ACT) && m_en[d][0] && (m_n0[d] < TOT) && in_reg(d, 0, int'(act_x), int'(act_y));
        h1 = (m_ph[d] == P_ACT) && m_en[d][1] && (m_n1[d] < TOT) && in_reg(d, 1, int'(act_x), int'(act_y));
        if (h0) begin
            m_addr[d] = m_n0[d] % (1 << AB); m_sel[d] = 2'b01; m_n0[d]++;
            if (h1) m_err[d] = 1'b1;
        end else if (h1) begin
            m_addr[d] = m_n1[d] % (1 << AB); m_sel[d] = 2'b10; m_n1[d]++;
        end else begin
            m_addr[d] = 0; m_sel[d] = 2'b00;
        end
        case (m_ph[d])
            P_IDLE, P_DONE: if (vsr) m_ph[d] = P_ARM;
            P_ARM: begin
                m_en[d] = cfg; m_n0[d] = 0; m_n1[d] = 0; m_err[d] = 1'b0;
                m_ph[d] = (cfg != 2'b00) ? P_ACT : P_DONE;
            end
            default: begin
                if (vsr) m_ph[d] = P_ARM;
                else if (ad) m_ph[d] = P_DONE;
            end
        endcase
    endtask

    task automatic check_dut(input int d);
        logic [31:0] o_addr, o_sel, o_fs, o_fd, o_busy, o_err;
        bit vsr, e_fd;
        if (d == 0) begin
            o_addr = 32'(addr_a); o_sel = 32'(sel_a); o_fs = 32'(fs_a);
            o_fd = 32'(fd_a); o_busy = 32'(busy_a); o_err = 32'(err_a);
        end else begin
            o_addr = 32'(addr_b); o_sel = 32'(sel_b); o_fs = 32'(fs_b);
            o_fd = 32'(fd_b); o_busy = 32'(busy_b); o_err = 32'(err_b);
        end
        vsr  = vs_in && !m_vsd[d] && !rst;
        e_fd = (m_ph[d] == P_ARM && cfg == 2'b00) || (m_ph[d] == P_ACT && !vsr && all_done(d));
        chk(d ? "B.rom_addr" : "A.rom_addr", o_addr, 32'(m_addr[d]));
        chk(d ? "B.rom_sel" : "A.rom_sel", o_sel, 32'(m_sel[d]));
        chk(d ? "B.frame_start" : "A.frame_start", o_fs, 32'(m_ph[d] == P_ARM));
        chk(d ? "B.frame_done" : "A.frame_done", o_fd, 32'(e_fd));
        chk(d ? "B.busy" : "A.busy", o_busy, 32'(m_ph[d] == P_ARM || m_ph[d] == P_ACT));
        chk(d ? "B.err_overlap" : "A.err_overlap", o_err, 32'(m_err[d]));
    endtask

    // Timing generator and event schedule.
    int hx = 0, vy = 0, fr = 0, vs_hold = 0, rst_hold = 3;
    int cnt0 = 0, cnt1 = 0;

    function automatic logic [1:0] next_cfg(input int f);
        case (f)
            1, 2:    return 2'b11;
            3:       return 2'b10;
            4:       return 2'b00;
            5:       return 2'b01;
            6, 7:    return 2'b11;
            default: return 2'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic drive_next();
        hx++;
        if (hx == HT) begin
            hx = 0;
            vy++;
            if (vy == VT) vy = 0;
        end
        if (hx == 0 && vy == VT - 1) fr++;
        if (hx == 0 && vy == VT - 2) cfg = next_cfg(fr + 1);
        if (fr == 4 && vy == 4 && hx == 0) cfg = 2'b11;
        if (fr == 6 && vy == 5 && hx == 17) vs_hold = 3;
        if (fr == 7 && vy == 5 && hx == 0) rst_hold = 2;
        if (fr >= 8) begin
            if ($urandom_range(0, 49) == 0) cfg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) vs_hold = $urandom_range(1, 4);
            if ($urandom_range(0, 1499) == 0) rst_hold = $urandom_range(1, 3);
        end
        rst = (rst_hold > 0);
        if (rst_hold > 0) rst_hold--;
        vs_in = (vy == VT - 1) || (vs_hold > 0);
        if (vs_hold > 0) vs_hold--;
        act_x = XB'(hx);
        act_y = YB'(vy);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ph[d] = P_IDLE; m_n0[d] = 0; m_n1[d] = 0; m_en[d] = 2'b00;
            m_err[d] = 1'b0; m_addr[d] = 0; m_sel[d] = 2'b00; m_vsd[d] = 1'b0;
        end
        rst = 1'b1; vs_in = 1'b0; cfg = 2'b00; act_x = '0; act_y = '0;
        while (fr < NFR) begin
            @(negedge clk);
            // Per-frame fetch totals for instance A, bounded by frame_start/frame_done.
            if (fs_a) begin
                cnt0 = 0; cnt1 = 0;
            end else begin
                if (sel_a == 2'b01) cnt0++;
                if (sel_a == 2'b10) cnt1++;
                if (fd_a) begin
                    chk("A.nfetch0", 32'(cnt0), m_en[0][0] ? 32'(TOT) : 32'd0);
                    chk("A.nfetch1", 32'(cnt1), m_en[0][1] ? 32'(TOT) : 32'd0);
                end
            end
            check_dut(0);
            check_dut(1);
            step(0);
            step(1);
            @(posedge clk);
            #1;
            drive_next();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
